// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - load/store stage with single-outstanding data-memory handshake
// Produces a registered writeback record; non-memory instructions pass through in one cycle.
module memory_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] memory_in,
  input  logic [XLEN-1:0] store_data,
  input  logic [3:0]      mem_op,
  input  logic [4:0]      rd_addr,
  input  logic            rd_we,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic            misaligned
);

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LW   = 4'd3;
  localparam logic [3:0] MEM_LBU  = 4'd4;
  localparam logic [3:0] MEM_LHU  = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;

  logic            is_load, is_store, is_half, is_word;
  logic            access, mis, accept, go_mem;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;

  // Captured at accept so the load result can be formed when the bus completes.
  logic [3:0]      op_q;
  logic [1:0]      ea_lo_q;
  logic [4:0]      rd_q;
  logic            rd_we_q;
  logic            load_q;
  logic [XLEN-1:0] shifted, load_val;

  assign in_ready = (state == IDLE);

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (mem_op)
      MEM_LB, MEM_LBU: is_load = 1'b1;
      MEM_LH, MEM_LHU: begin is_load = 1'b1; is_half = 1'b1; end
      MEM_LW:          begin is_load = 1'b1; is_word = 1'b1; end
      MEM_SB:          is_store = 1'b1;
      MEM_SH:          begin is_store = 1'b1; is_half = 1'b1; end
      MEM_SW:          begin is_store = 1'b1; is_word = 1'b1; end
      default:         ;
    endcase
    access = is_load || is_store;
    mis    = access && ((is_half && memory_in[0]) || (is_word && (memory_in[1:0] != 2'b00)));
    accept = in_valid && in_ready;
    go_mem = accept && access && !mis;
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data;
    if (is_half) begin
      st_be    = memory_in[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{store_data[15:0]}};
    end else if (!is_word) begin
      st_be    = 4'b0001 << memory_in[1:0];
      st_wdata = {4{store_data[7:0]}};
    end
  end

  always_comb begin
    load_q   = (op_q == MEM_LB) || (op_q == MEM_LH) || (op_q == MEM_LW) ||
               (op_q == MEM_LBU) || (op_q == MEM_LHU);
    shifted  = dmem_rdata >> {ea_lo_q, 3'b000};
    load_val = dmem_rdata;
    case (op_q)
      MEM_LB:  load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      MEM_LH:  load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      MEM_LBU: load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
      MEM_LHU: load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_mem) state_nxt = BUSY;
      BUSY:    if (dmem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= 4'b0000;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= 5'd0;
      wb_we      <= 1'b0;
      misaligned <= 1'b0;
      op_q       <= MEM_NONE;
      ea_lo_q    <= 2'b00;
      rd_q       <= 5'd0;
      rd_we_q    <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
      if (accept) begin
        op_q    <= mem_op;
        ea_lo_q <= memory_in[1:0];
        rd_q    <= rd_addr;
        rd_we_q <= rd_we;
        if (go_mem) begin
          dmem_req   <= 1'b1;
          dmem_we    <= is_store;
          dmem_addr  <= {memory_in[XLEN-1:2], 2'b00};
          dmem_be    <= is_store ? st_be : 4'b1111;
          dmem_wdata <= is_store ? st_wdata : '0;
        end else begin
          // Pass-through and misaligned faults both report memory_in; faults never write rd.
          wb_valid   <= 1'b1;
          wb_data    <= memory_in;
          wb_rd      <= rd_addr;
          wb_we      <= !access && rd_we && (rd_addr != 5'd0);
          misaligned <= mis;
        end
      end else if (state == BUSY && dmem_ready) begin
        dmem_req <= 1'b0;
        wb_valid <= 1'b1;
        wb_data  <= load_q ? load_val : '0;
        wb_rd    <= rd_q;
        wb_we    <= load_q && rd_we_q && (rd_q != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard bench for memory_stage with a behavioural reference model
module tb_memory_stage;

  localparam int NONE = 0, LB = 1, LH = 2, LW = 3, LBU = 4, LHU = 5, SB = 6, SH = 7, SW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] memory_in, store_data;
  logic [3:0]  mem_op;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        misaligned;

  memory_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .memory_in(memory_in), .store_data(store_data), .mem_op(mem_op),
    .rd_addr(rd_addr), .rd_we(rd_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        mis;
  } wb_t;

  wb_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int size_of(input int op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_model(input int op, input logic [31:0] ea, input logic [31:0] rdata);
    logic [31:0] s, v;
    s = rdata >> (8 * (ea % 4));
    case (op)
      LB:      begin v = s % 256;   if (v >= 128)   v = v - 32'd256;   end
      LH:      begin v = s % 65536; if (v >= 32768) v = v - 32'd65536; end
      LBU:     v = s % 256;
      LHU:     v = s % 65536;
      default: v = rdata;
    endcase
    return v;
  endfunction

  initial begin : monitor
    wb_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (misaligned) chk("mis_with_wb_valid", {31'd0, wb_valid}, 32'd1);
        if (wb_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_wb_valid", {31'd0, wb_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("wb_data", wb_data, e.data);
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
            chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int op, input logic [31:0] ea, input logic [31:0] sd,
                       input logic [4:0] rd, input logic we, input logic [31:0] rdata, input int lat);
    int          sz;
    bit          mem, mis, st;
    wb_t         e;
    logic [3:0]  be;
    logic [31:0] wd;
    sz  = size_of(op);
    mem = (sz != 0);
    mis = mem && ((ea % sz) != 0);
    st  = (op == SB) || (op == SH) || (op == SW);
    e.rd = rd;
    e.mis = mis;
    if (!mem)     begin e.data = ea; e.we = we && (rd != 0); end
    else if (mis) begin e.data = ea; e.we = 1'b0; end
    else if (st)  begin e.data = 32'd0; e.we = 1'b0; end
    else          begin e.data = load_model(op, ea, rdata); e.we = we && (rd != 0); end
    be = 4'b1111;
    wd = 32'd0;
    if (op == SB) begin be = 4'd1 << (ea % 4); wd = (sd % 256) * 32'h0101_0101; end
    if (op == SH) begin be = ((ea % 4) >= 2) ? 4'b1100 : 4'b0011; wd = (sd % 65536) * 32'h0001_0001; end
    if (op == SW) wd = sd;

    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid   = 1'b1;
    mem_op     = 4'(op);
    memory_in  = ea;
    store_data = sd;
    rd_addr    = rd;
    rd_we      = we;
    dmem_ready = 1'($urandom_range(0, 1));
    exp_q.push_back(e);
    step();
    in_valid   = 1'b0;
    dmem_ready = 1'b0;
    mem_op     = 4'($urandom_range(0, 15));
    memory_in  = $urandom;
    if (mem && !mis) begin
      chk("dmem_req", {31'd0, dmem_req}, 32'd1);
      chk("dmem_we", {31'd0, dmem_we}, {31'd0, st});
      chk("dmem_addr", dmem_addr, ea & 32'hFFFF_FFFC);
      chk("dmem_be", {28'd0, dmem_be}, {28'd0, be});
      chk("dmem_wdata", dmem_wdata, wd);
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < lat; i++) begin
        step();
        chk("dmem_req_hold", {31'd0, dmem_req}, 32'd1);
        chk("dmem_addr_hold", dmem_addr, ea & 32'hFFFF_FFFC);
        chk("dmem_be_hold", {28'd0, dmem_be}, {28'd0, be});
        chk("in_ready_wait", {31'd0, in_ready}, 32'd0);
      end
      dmem_ready = 1'b1;
      dmem_rdata = rdata;
      step();
      dmem_ready = 1'b0;
      dmem_rdata = $urandom;
      chk("dmem_req_drop", {31'd0, dmem_req}, 32'd0);
      chk("in_ready_after", {31'd0, in_ready}, 32'd1);
    end else begin
      chk("no_dmem_req", {31'd0, dmem_req}, 32'd0);
    end
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int op;
    logic [31:0] ea;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    memory_in  = 32'd0;
    store_data = 32'd0;
    mem_op     = 4'd0;
    rd_addr    = 5'd0;
    rd_we      = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    issue(NONE, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 32'd0, 0);
    issue(SB, 32'h0000_0103, 32'h0000_00AB, 5'd7, 1'b0, 32'd0, 0);
    issue(LH, 32'h0000_0202, 32'd0, 5'd9, 1'b1, 32'h8001_0000, 3);
    issue(LHU, 32'h0000_0202, 32'd0, 5'd9, 1'b1, 32'h8001_0000, 3);
    issue(LW, 32'h0000_0301, 32'd0, 5'd3, 1'b1, 32'd0, 0);
    issue(LW, 32'h0000_0400, 32'd0, 5'd0, 1'b1, 32'hDEAD_BEEF, 1);
    issue(SH, 32'h0000_0506, 32'h1234_5678, 5'd1, 1'b0, 32'd0, 2);
    issue(LB, 32'h0000_0601, 32'd0, 5'd4, 1'b1, 32'h0000_8000, 0);
    for (int i = 0; i < 4; i++) issue(NONE, $urandom, 32'd0, 5'(i), 1'b1, 32'd0, 0);
    issue(4'd12, 32'hCAFE_0001, 32'd0, 5'd6, 1'b1, 32'd0, 0);

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 10);
      ea = $urandom;
      issue(op, ea, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom, $urandom_range(0, 3));
    end

    // Abandon an access with reset while BUSY: req drops at once, no writeback follows.
    step();
    in_valid  = 1'b1;
    mem_op    = 4'(LW);
    memory_in = 32'h0000_0800;
    rd_addr   = 5'd2;
    rd_we     = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("busy_req_before_reset", {31'd0, dmem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_req", {31'd0, dmem_req}, 32'd0);
    chk("async_reset_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_reset_req", {31'd0, dmem_req}, 32'd0);
    step();
    step();
    step();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
